// File: rtl/deserializer_aligner.sv
// Serial-to-parallel deserializer. It hunts for FLAG_PAT at any bit offset and confirms alignment
// over LOCK_CNT flags. Once locked it emits aligned symbols and flags misaligned frame flags.
module deserializer_aligner #(
  parameter int unsigned      SYM_W    = 10,
  parameter logic [SYM_W-1:0] FLAG_PAT = 10'h07E,
  parameter int unsigned      LOCK_CNT = 3,
  parameter int unsigned      MAX_GAP  = 64,
  parameter int unsigned      ERR_MAX  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_i,
  output logic [SYM_W-1:0] sym_o,
  output logic             sym_valid_o,
  output logic             st_flag,
  output logic             locked_o,
  output logic             align_err_o
);

  localparam int unsigned BitW  = $clog2(SYM_W);
  localparam int unsigned GoodW = $clog2(LOCK_CNT + 1);
  localparam int unsigned GapW  = $clog2(MAX_GAP + 1);
  localparam int unsigned ErrW  = $clog2(ERR_MAX + 1);

  localparam logic [BitW-1:0]  BitLast = BitW'(SYM_W - 1);
  localparam logic [GoodW-1:0] GoodLim = GoodW'(LOCK_CNT);
  localparam logic [GapW-1:0]  GapLim  = GapW'(MAX_GAP);
  localparam logic [ErrW-1:0]  ErrLim  = ErrW'(ERR_MAX);

  typedef enum logic [1:0] {StHunt, StSync, StLocked} state_e;

  state_e           state_q, state_d;
  logic [SYM_W-1:0] shreg_q;
  logic [BitW-1:0]  bit_cnt_q, bit_cnt_d, bit_inc;
  logic [GoodW-1:0] good_cnt_q, good_cnt_d, good_inc;
  logic [GapW-1:0]  gap_cnt_q, gap_cnt_d, gap_inc;
  logic [ErrW-1:0]  err_cnt_q, err_cnt_d, err_inc;
  logic [SYM_W-1:0] sym_q, sym_d;
  logic             sym_valid_q, sym_valid_d;
  logic             st_flag_q, st_flag_d;
  logic             align_err_q, align_err_d;
  logic             hit, boundary;

  assign hit      = (shreg_q == FLAG_PAT);
  assign boundary = (bit_cnt_q == '0);
  assign bit_inc  = (bit_cnt_q == BitLast) ? '0 : bit_cnt_q + 1'b1;
  assign good_inc = good_cnt_q + 1'b1;
  assign gap_inc  = gap_cnt_q + 1'b1;
  assign err_inc  = err_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    good_cnt_d  = good_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    err_cnt_d   = err_cnt_q;
    sym_d       = sym_q;
    sym_valid_d = 1'b0;
    st_flag_d   = 1'b0;
    align_err_d = 1'b0;
    unique case (state_q)
      StHunt: begin
        bit_cnt_d = '0;
        if (hit) begin
          bit_cnt_d  = BitW'(1);
          good_cnt_d = GoodW'(1);
          gap_cnt_d  = '0;
          state_d    = (LOCK_CNT == 1) ? StLocked : StSync;
        end
      end
      StSync: begin
        bit_cnt_d = bit_inc;
        if (boundary) begin
          if (hit) begin
            good_cnt_d = good_inc;
            gap_cnt_d  = '0;
            if (good_inc == GoodLim) state_d = StLocked;
          end else begin
            gap_cnt_d = gap_inc;
            if (gap_inc == GapLim) begin
              state_d    = StHunt;
              bit_cnt_d  = '0;
              gap_cnt_d  = '0;
              good_cnt_d = '0;
            end
          end
        end else if (hit) begin
          // Flag at a new offset: restart confirmation from this alignment.
          bit_cnt_d  = BitW'(1);
          good_cnt_d = GoodW'(1);
          gap_cnt_d  = '0;
        end
      end
      StLocked: begin
        bit_cnt_d = bit_inc;
        if (boundary) begin
          sym_d       = shreg_q;
          sym_valid_d = 1'b1;
          st_flag_d   = hit;
          if (hit) err_cnt_d = '0;
        end else if (hit) begin
          err_cnt_d   = err_inc;
          align_err_d = 1'b1;
          if (err_inc == ErrLim) begin
            state_d   = StHunt;
            err_cnt_d = '0;
            bit_cnt_d = '0;
          end
        end
      end
      default: state_d = StHunt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StHunt;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      good_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      err_cnt_q   <= '0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      st_flag_q   <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= {shreg_q[SYM_W-2:0], serial_i};
      bit_cnt_q   <= bit_cnt_d;
      good_cnt_q  <= good_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      err_cnt_q   <= err_cnt_d;
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
      st_flag_q   <= st_flag_d;
      align_err_q <= align_err_d;
    end
  end

  assign sym_o       = sym_q;
  assign sym_valid_o = sym_valid_q;
  assign st_flag     = st_flag_q;
  assign locked_o    = (state_q == StLocked);
  assign align_err_o = align_err_q;

endmodule

// File: tb/tb_deserializer_aligner.sv
// Bench for deserializer_aligner: a 10-bit/LOCK_CNT=3 instance and an 8-bit/LOCK_CNT=1 instance,
// driven one at a time, with a shared scoreboard of expected symbols.
module tb_deserializer_aligner;

  localparam logic [9:0] FlagA = 10'h07E;
  localparam logic [9:0] FlagB = 10'h07E;  // 8'h7E zero-extended

  typedef struct packed {
    logic [9:0] sym;
    logic       flag;
  } exp_t;

  typedef struct {
    logic [9:0] sym;
    bit         exp_vld;
    bit         exp_flag;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset, ser_a, ser_b;
  logic [9:0] sym_a;
  logic [7:0] sym_b;
  logic       vld_a, vld_b, stf_a, stf_b, lk_a, lk_b, ae_a, ae_b;

  deserializer_aligner u_dut_a (
    .clk        (clk),
    .reset      (reset),
    .serial_i   (ser_a),
    .sym_o      (sym_a),
    .sym_valid_o(vld_a),
    .st_flag    (stf_a),
    .locked_o   (lk_a),
    .align_err_o(ae_a)
  );

  deserializer_aligner #(
    .SYM_W   (8),
    .FLAG_PAT(8'h7E),
    .LOCK_CNT(1)
  ) u_dut_b (
    .clk        (clk),
    .reset      (reset),
    .serial_i   (ser_b),
    .sym_o      (sym_b),
    .sym_valid_o(vld_b),
    .st_flag    (stf_b),
    .locked_o   (lk_b),
    .align_err_o(ae_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_chk = 0;
  int   n_pass = 0;
  exp_t exp_q[$];
  int   sel = 0;
  vec_t tbl[35];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Monitor state, indexed 0 = 10-bit DUT, 1 = 8-bit DUT.
  logic [9:0] m_sym[2];
  logic       m_vld[2], m_st[2], m_lk[2], m_ae[2];
  logic       lk_prev[2] = '{1'b0, 1'b0};
  logic       err_locked[2] = '{1'b0, 1'b0};
  int         lock_cyc[2] = '{-1, -1};
  int         prev_vld[2] = '{-1, -1};
  int         err_pulses[2] = '{0, 0};
  int         lock_rises[2] = '{0, 0};
  exp_t       mon_e;

  assign m_sym[0] = sym_a;
  assign m_sym[1] = {2'b00, sym_b};
  assign m_vld[0] = vld_a;
  assign m_vld[1] = vld_b;
  assign m_st[0]  = stf_a;
  assign m_st[1]  = stf_b;
  assign m_lk[0]  = lk_a;
  assign m_lk[1]  = lk_b;
  assign m_ae[0]  = ae_a;
  assign m_ae[1]  = ae_b;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk("output_gating", int'({m_vld[d] & ~m_lk[d], m_st[d] & ~m_vld[d]}), 0);
      if (m_lk[d] && !lk_prev[d]) begin
        lock_cyc[d] = cyc;
        prev_vld[d] = -1;
        lock_rises[d]++;
      end
      if (!m_lk[d]) begin
        lock_cyc[d] = -1;
        prev_vld[d] = -1;
      end
      if (m_vld[d]) begin
        chk("sb_has_entry", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("sym_o", int'(m_sym[d]), int'(mon_e.sym));
          chk("st_flag", int'(m_st[d]), int'(mon_e.flag));
        end
        if (prev_vld[d] >= 0) chk("vld_period", cyc - prev_vld[d], (d == 0) ? 10 : 8);
        else chk("first_vld_after_lock", cyc - lock_cyc[d], (d == 0) ? 10 : 8);
        prev_vld[d] = cyc;
      end
      if (m_ae[d]) begin
        err_pulses[d]++;
        err_locked[d] = m_lk[d];
      end
      lk_prev[d] = m_lk[d];
    end
  end

  function automatic logic [9:0] rnd_a();
    // Masked so data never contains a run of six ones, hence never aliases the flag.
    return 10'($urandom & 32'h3DE);
  endfunction

  function automatic logic [9:0] rnd_b();
    return 10'($urandom & 32'hEE);
  endfunction

  task automatic send_bit(input logic b);
    if (sel == 0) ser_a = b;
    else ser_b = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input logic [9:0] v, input bit expv, input bit expf);
    exp_t e;
    int   w;
    w = (sel == 0) ? 10 : 8;
    if (expv) begin
      e.sym  = v;
      e.flag = expf;
      exp_q.push_back(e);
    end
    for (int i = w - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  // One zero, a flag, nine zeros: a flag one bit late, leaving alignment intact afterwards.
  task automatic send_chunk(input bit tail_exp);
    exp_t e;
    e.sym  = 10'h03F;
    e.flag = 1'b0;
    exp_q.push_back(e);
    if (tail_exp) begin
      e.sym = 10'h000;
      exp_q.push_back(e);
    end
    send_bit(1'b0);
    send_sym(FlagA, 1'b0, 1'b0);
    repeat (9) send_bit(1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ser_a = 1'b0;
    ser_b = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    for (int d = 0; d < 2; d++) begin
      err_pulses[d] = 0;
      lock_rises[d] = 0;
    end
    chk("reset_outputs_a", int'({sym_a, vld_a, stf_a, lk_a, ae_a}), 0);
    chk("reset_outputs_b", int'({sym_b, vld_b, stf_b, lk_b, ae_b}), 0);
  endtask

  task automatic finish_scn();
    send_bit(1'b0);
    send_bit(1'b0);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    int t;
    reset = 1'b1;
    ser_a = 1'b0;
    ser_b = 1'b0;
    // Lock stream: 3 random symbols, then 4 x (flag + 7 data). Lock at entry 19 (third flag).
    for (int i = 0; i < 35; i++) begin
      if (i >= 3 && (i - 3) % 8 == 0) begin
        tbl[i].sym      = FlagA;
        tbl[i].exp_flag = 1'b1;
      end else begin
        tbl[i].sym      = rnd_a();
        tbl[i].exp_flag = 1'b0;
      end
      tbl[i].exp_vld = (i > 19);
    end
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Lock at bit offset 3.
    sel = 0;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    t = 0;
    for (int i = 0; i < 35; i++) begin
      send_sym(tbl[i].sym, tbl[i].exp_vld, tbl[i].exp_flag);
      if (i == 19) begin
        t = cyc;
        chk("lock_not_early", int'(lk_a), 0);
      end
    end
    chk("lock_edge", lock_cyc[0], t + 1);
    chk("lock_rises", lock_rises[0], 1);
    chk("lock_no_align_err", err_pulses[0], 0);
    finish_scn();

    // SYNC timeout after 64 flagless symbols.
    do_reset();
    send_sym(FlagA, 1'b0, 1'b1);
    repeat (64) send_sym(10'h155, 1'b0, 1'b0);
    send_sym(FlagA, 1'b0, 1'b1);
    send_sym(FlagA, 1'b0, 1'b1);
    send_sym(rnd_a(), 1'b0, 1'b0);
    chk("timeout_never_locked", lock_rises[0], 0);
    chk("timeout_back_to_hunt", int'(lk_a), 0);
    send_sym(FlagA, 1'b0, 1'b1);
    send_sym(rnd_a(), 1'b1, 1'b0);
    chk("relock_after_timeout", int'(lk_a), 1);
    finish_scn();

    // SYNC re-align by 2 bits.
    do_reset();
    send_sym(FlagA, 1'b0, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_sym(FlagA, 1'b0, 1'b1);
    send_sym(FlagA, 1'b0, 1'b1);
    send_sym(rnd_a(), 1'b0, 1'b0);
    chk("realign_not_early", int'(lk_a), 0);
    send_sym(FlagA, 1'b0, 1'b1);
    t = cyc;
    send_sym(rnd_a(), 1'b1, 1'b0);
    chk("realign_lock_edge", lock_cyc[0], t + 1);

    // Loss of lock: 3 misaligned then aligned clears; 3 more hold; then 4 in a row unlock.
    for (int i = 1; i <= 3; i++) begin
      send_chunk(1'b1);
      chk("err_pulses", err_pulses[0], i);
      chk("lock_held", int'(lk_a), 1);
    end
    send_sym(FlagA, 1'b1, 1'b1);
    for (int i = 4; i <= 6; i++) begin
      send_chunk(1'b1);
      chk("err_pulses", err_pulses[0], i);
      chk("lock_held_after_clear", int'(lk_a), 1);
    end
    chk("err_pulse_while_locked", int'(err_locked[0]), 1);
    send_sym(FlagA, 1'b1, 1'b1);
    for (int i = 7; i <= 10; i++) begin
      send_chunk(i < 10);
      chk("err_pulses", err_pulses[0], i);
      chk("lock_state", int'(lk_a), (i < 10) ? 1 : 0);
    end
    chk("unlock_on_4th_pulse", int'(err_locked[0]), 0);
    finish_scn();

    // Reset mid-symbol while locked, then a full relock.
    do_reset();
    repeat (3) send_sym(FlagA, 1'b0, 1'b1);
    send_sym(rnd_a(), 1'b1, 1'b0);
    repeat (4) send_bit(1'($urandom & 1));
    chk("locked_before_reset", int'(lk_a), 1);
    do_reset();
    send_sym(FlagA, 1'b0, 1'b1);
    send_sym(FlagA, 1'b0, 1'b1);
    send_sym(rnd_a(), 1'b0, 1'b0);
    chk("relock_needs_three", int'(lk_a), 0);
    send_sym(FlagA, 1'b0, 1'b1);
    send_sym(rnd_a(), 1'b1, 1'b0);
    chk("relock_after_reset", int'(lk_a), 1);
    finish_scn();

    // 8-bit instance, LOCK_CNT = 1.
    do_reset();
    sel = 1;
    send_bit(1'b1);
    send_bit(1'b0);
    send_sym(rnd_b(), 1'b0, 1'b0);
    send_sym(rnd_b(), 1'b0, 1'b0);
    send_sym(FlagB, 1'b0, 1'b1);
    t = cyc;
    chk("b_lock_not_early", int'(lk_b), 0);
    for (int i = 0; i < 14; i++) begin
      if (i == 6) send_sym(FlagB, 1'b1, 1'b1);
      else send_sym(rnd_b(), 1'b1, 1'b0);
    end
    chk("b_lock_edge", lock_cyc[1], t + 1);
    chk("b_no_align_err", err_pulses[1], 0);
    chk("a_idle_unlocked", int'(lk_a), 0);
    finish_scn();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
